// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Byte-wide memory/IO responder sitting behind a simple memory controller.
//   Addresses with mem_addr[17:16] == 2'b11 select the IO region; all other
//   addresses hit an internal RAM of 2^RAM_AW bytes. The IO region exposes a
//   TX FIFO (write 0x30000), an RX holding register (read 0x30000), a status
//   byte (read 0x30004) and a sticky halt request (write 0x30004).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global ready; when low, controller accesses are ignored
//   mem_addr/wr/din : controller byte address, write strobe, write data
//   mem_dout        : registered read data (1-cycle latency)
//   io_buffer_full  : TX FIFO within 2 entries of full (controller holds writes)
//   tx_data/valid   : head of TX FIFO / FIFO non-empty
//   tx_ready        : sink accepts the head byte
//   rx_data/valid   : incoming byte and its single-cycle strobe
//   tx_overflow     : sticky, an IO write was dropped on a full FIFO
//   rx_overrun      : sticky, an RX byte was dropped on an occupied register
//   sim_halt        : sticky, program requested a halt
module mem_io_responder #(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tx_overflow,
  output logic        rx_overrun,
  output logic        sim_halt
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(TX_DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(TX_DEPTH - 2);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE_C   = PW'(1'b1);

  // Storage
  logic [7:0]    ram_r  [2**RAM_AW];
  logic [7:0]    fifo_r [TX_DEPTH];

  // State registers
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [7:0]    mem_dout_r;
  logic [7:0]    rx_hold_r;
  logic          rx_full_r;
  logic          tx_overflow_r;
  logic          rx_overrun_r;
  logic          sim_halt_r;

  // Decoded access strobes
  logic          io_sel_s;
  logic [15:0]   io_off_s;
  logic          acc_rd_s;
  logic          acc_wr_s;
  logic          ram_wr_s;
  logic          tx_push_req_s;
  logic          tx_push_s;
  logic          tx_pop_s;
  logic          tx_drop_s;
  logic          halt_wr_s;
  logic          rx_rd_s;
  logic          tx_empty_s;
  logic [7:0]    rd_data_s;

  // Upper address bits are outside the decoded window.
  logic          unused_s;
  assign unused_s = ^mem_addr[31:18];

  // Address decode and FIFO push/pop qualification
  always_comb begin
    io_sel_s      = (mem_addr[17:16] == 2'b11);
    io_off_s      = mem_addr[15:0];
    acc_wr_s      = rdy & mem_wr;
    acc_rd_s      = rdy & ~mem_wr;
    ram_wr_s      = acc_wr_s & ~io_sel_s;
    tx_push_req_s = acc_wr_s & io_sel_s & (io_off_s == 16'h0000);
    halt_wr_s     = acc_wr_s & io_sel_s & (io_off_s == 16'h0004);
    rx_rd_s       = acc_rd_s & io_sel_s & (io_off_s == 16'h0000);
    tx_empty_s    = (count_r == {CW{1'b0}});
    tx_pop_s      = ~tx_empty_s & tx_ready;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still fits.
    tx_push_s     = tx_push_req_s & ((count_r < DEPTH_C) | tx_pop_s);
    tx_drop_s     = tx_push_req_s & ~tx_push_s;
  end

  // Read-data mux: RAM byte or IO register
  always_comb begin
    rd_data_s = 8'h00;
    if (io_sel_s) begin
      case (io_off_s)
        16'h0000: rd_data_s = rx_hold_r;
        16'h0004: rd_data_s = {6'b000000, tx_empty_s, rx_full_r};
        default:  rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = ram_r[mem_addr[RAM_AW-1:0]];
    end
  end

  // RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      ram_r[mem_addr[RAM_AW-1:0]] <= mem_din;
    end
  end

  // TX FIFO storage write port (contents are don't-care after reset)
  always_ff @(posedge clk) begin
    if (!rst && tx_push_s) begin
      fifo_r[tail_r] <= mem_din;
    end
  end

  // Control state: read data, FIFO pointers, RX register and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dout_r    <= 8'h00;
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      rx_hold_r     <= 8'h00;
      rx_full_r     <= 1'b0;
      tx_overflow_r <= 1'b0;
      rx_overrun_r  <= 1'b0;
      sim_halt_r    <= 1'b0;
    end else begin
      if (acc_rd_s) begin
        mem_dout_r <= rd_data_s;
      end

      if (tx_pop_s) begin
        head_r <= head_r + PTR_ONE_C;
      end
      if (tx_push_s) begin
        tail_r <= tail_r + PTR_ONE_C;
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
      if (tx_drop_s) begin
        tx_overflow_r <= 1'b1;
      end

      if (halt_wr_s) begin
        sim_halt_r <= 1'b1;
      end

      // A read of the holding register in the same cycle frees it for the
      // incoming byte; the read itself still returns the old byte.
      if (rx_valid) begin
        if (!rx_full_r || rx_rd_s) begin
          rx_hold_r <= rx_data;
          rx_full_r <= 1'b1;
        end else begin
          rx_overrun_r <= 1'b1;
        end
      end else if (rx_rd_s) begin
        rx_full_r <= 1'b0;
      end
    end
  end

  assign mem_dout       = mem_dout_r;
  assign tx_data        = fifo_r[head_r];
  assign tx_valid       = ~tx_empty_s;
  assign io_buffer_full = (count_r >= NEAR_FULL_C);
  assign tx_overflow    = tx_overflow_r;
  assign rx_overrun     = rx_overrun_r;
  assign sim_halt       = sim_halt_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
//   Directed bench for mem_io_responder. Every tick runs a reference model
//   of the RAM, TX FIFO, RX register and sticky flags; read expectations go
//   into a scoreboard queue at issue time and are compared when mem_dout
//   updates. Directed steps add explicit checks for the key scenarios.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_overflow;
  logic        rx_overrun;
  logic        sim_halt;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_overflow(tx_overflow),
    .rx_overrun(rx_overrun), .sim_halt(sim_halt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rdq[$];
  logic [7:0] ram_m [int];
  logic [7:0] last_dout = 8'h00;
  logic [7:0] rx_hold_m = 8'h00;
  bit         rx_full_m = 1'b0;
  bit         ovf_m = 1'b0;
  bit         ovr_m = 1'b0;
  bit         halt_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic tick();
    bit          io_s, do_rd, pop_m, push_m, rx_rd_m;
    logic [15:0] off;
    logic [7:0]  exp_rd;
    int          sz;
    io_s  = (mem_addr[17:16] == 2'b11);
    off   = mem_addr[15:0];
    do_rd = 1'b0;
    if (rst) begin
      txq.delete();
      rdq.delete();
      last_dout = 8'h00;
      rx_hold_m = 8'h00;
      rx_full_m = 1'b0;
      ovf_m = 1'b0;
      ovr_m = 1'b0;
      halt_m = 1'b0;
    end else begin
      sz    = txq.size();
      pop_m = tx_ready && (sz != 0);
      if (pop_m) chk("tx_head", tx_data, txq[0]);
      do_rd = rdy && !mem_wr;
      if (do_rd) begin
        if (io_s) begin
          if (off == 16'h0000) exp_rd = rx_hold_m;
          else if (off == 16'h0004) exp_rd = {6'b000000, sz == 0, rx_full_m};
          else exp_rd = 8'h00;
        end else begin
          exp_rd = ram_m.exists(int'(mem_addr[16:0])) ? ram_m[int'(mem_addr[16:0])] : 8'hxx;
        end
        rdq.push_back(exp_rd);
      end
      rx_rd_m = do_rd && io_s && (off == 16'h0000);
      if (rx_valid) begin
        if (!rx_full_m || rx_rd_m) begin
          rx_hold_m = rx_data;
          rx_full_m = 1'b1;
        end else begin
          ovr_m = 1'b1;
        end
      end else if (rx_rd_m) begin
        rx_full_m = 1'b0;
      end
      if (rdy && mem_wr && io_s && off == 16'h0004) halt_m = 1'b1;
      if (rdy && mem_wr && !io_s) ram_m[int'(mem_addr[16:0])] = mem_din;
      push_m = rdy && mem_wr && io_s && (off == 16'h0000);
      if (pop_m) void'(txq.pop_front());
      if (push_m) begin
        if (sz < 8 || pop_m) txq.push_back(mem_din);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (do_rd) last_dout = rdq.pop_front();
    chk("mem_dout", mem_dout, last_dout);
    chk("tx_valid", tx_valid, txq.size() != 0);
    chk("io_buffer_full", io_buffer_full, txq.size() >= 6);
    chk("tx_overflow", tx_overflow, ovf_m);
    chk("rx_overrun", rx_overrun, ovr_m);
    chk("sim_halt", sim_halt, halt_m);
  endtask

  task automatic drv(input bit r, input bit w, input logic [31:0] a, input logic [7:0] d);
    rdy = r; mem_wr = w; mem_addr = a; mem_din = d;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    drv(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drv(1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    idle();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0; mem_din = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset state
    idle();
    idle();
    rst = 1'b0;
    chk("rst_dout", mem_dout, 8'h00);
    chk("rst_txv", tx_valid, 1'b0);

    // RAM write then read on the next cycle, plus a few patterns
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010);
    chk("raw_a5", mem_dout, 8'hA5);
    for (int i = 0; i < 4; i++) wr(32'h100 + i, 8'h3C ^ 8'(i * 17));
    wr(32'h0001_FFFF, 8'h7E);
    for (int i = 0; i < 4; i++) rd(32'h100 + i);
    rd(32'h0001_FFFF);
    chk("ram_top", mem_dout, 8'h7E);
    // A write cycle leaves mem_dout untouched
    wr(32'h0000_0200, 8'h99);
    chk("wr_hold", mem_dout, 8'h7E);
    rd(32'h0003_0010);
    chk("io_other", mem_dout, 8'h00);

    // Fill FIFO with the sink stalled, overflow on the 9th write
    for (int k = 1; k <= 8; k++) begin
      wr(32'h0003_0000, 8'h40 + 8'(k));
      chk("ibf_k", io_buffer_full, k >= 6);
    end
    chk("ovf_pre", tx_overflow, 1'b0);
    wr(32'h0003_0000, 8'h49);
    chk("ovf_9th", tx_overflow, 1'b1);
    rd(32'h0003_0004);
    chk("stat_full", mem_dout, 8'h00);
    // Drain with rdy low: the sink still drains
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) idle();
    chk("drained", tx_valid, 1'b0);
    rd(32'h0003_0004);
    chk("stat_empty", mem_dout, 8'h02);

    // Push+pop at 7 entries and at full, across pointer wrap
    do_reset();
    for (int k = 0; k < 5; k++) wr(32'h0003_0000, 8'h50 + 8'(k));
    idle();
    idle();
    tx_ready = 1'b0;
    for (int k = 0; k < 7; k++) wr(32'h0003_0000, 8'h60 + 8'(k));
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h67);
    chk("pp7_head", tx_data, 8'h61);
    chk("pp7_ibf", io_buffer_full, 1'b1);
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h68);
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h69);
    chk("pp8_ovf", tx_overflow, 1'b0);
    for (int k = 0; k < 9; k++) idle();
    chk("pp_drained", tx_valid, 1'b0);

    // RX overrun, read returns the first byte, status with/without TX data
    do_reset();
    rx_strobe(8'h5A);
    rx_strobe(8'h33);
    rd(32'h0003_0000);
    chk("rx_first", mem_dout, 8'h5A);
    chk("rx_ovr", rx_overrun, 1'b1);
    rd(32'h0003_0004);
    chk("stat_e", mem_dout, 8'h02);
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'hC1);
    rd(32'h0003_0004);
    chk("stat_ne", mem_dout, 8'h00);
    // Capture colliding with a read of the holding register
    rx_strobe(8'h77);
    rx_valid = 1'b1; rx_data = 8'h88;
    rd(32'h0003_0000);
    rx_valid = 1'b0;
    chk("rx_coll_old", mem_dout, 8'h77);
    rd(32'h0003_0004);
    chk("rx_coll_full", mem_dout, 8'h01);
    rd(32'h0003_0000);
    chk("rx_coll_new", mem_dout, 8'h88);

    // rdy low blocks RAM write, halt and rx_full clear
    wr(32'h0000_0020, 8'h11);
    drv(1'b0, 1'b1, 32'h0000_0020, 8'hFF);
    drv(1'b0, 1'b1, 32'h0003_0004, 8'hFF);
    chk("halt_blk", sim_halt, 1'b0);
    rx_strobe(8'h4D);
    drv(1'b0, 1'b0, 32'h0003_0000, 8'h00);
    rd(32'h0000_0020);
    chk("ram_blk", mem_dout, 8'h11);
    rd(32'h0003_0004);
    chk("rx_kept", mem_dout, 8'h01);
    wr(32'h0003_0004, 8'hFF);
    chk("halt_set", sim_halt, 1'b1);

    // Reset with TX bytes queued and RX full
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) wr(32'h0003_0000, 8'hD0 + 8'(k));
    tx_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hEE;
    do_reset();
    rx_valid = 1'b0;
    chk("rst_txv2", tx_valid, 1'b0);
    chk("rst_halt", sim_halt, 1'b0);
    chk("rst_ovr", rx_overrun, 1'b0);
    rd(32'h0003_0004);
    chk("rst_stat", mem_dout, 8'h02);
    rd(32'h0000_0010);
    chk("ram_keep1", mem_dout, 8'hA5);
    rd(32'h0000_0020);
    chk("ram_keep2", mem_dout, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
